// File: rtl/inflate_out_writer.sv
// Packs the 16-bit inflate stream into words and writes them out over AHB-Lite.
// Optional INFLATE_OUT_ADLER_EN adds a running Adler-32 of the accepted bytes.
module inflate_out_writer #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] PAD_VALUE  = 16'h0,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [31:0]      cfg_base_addr,
  input  logic [15:0]      in_data,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic             in_finish,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [31:0]      HWDATA,
  input  logic             HREADY,
  output logic             wr_busy,
  output logic             wr_done,
  output logic [CNT_W-1:0] wr_word_cnt
`ifdef INFLATE_OUT_ADLER_EN
  ,
  output logic [31:0]      adler_out
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA
  } wstate_t;

  state_t  state, state_nx;
  wstate_t wstate, wstate_nx;

  logic [31:0]      base;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      half;
  logic             half_vld;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      fcnt;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  logic [31:0]      push_data;
  logic             accept, start;

  assign fifo_full  = (fcnt == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (fcnt == '0);

  assign start  = cfg_start &&
                  ((state == S_IDLE) || (state == S_DONE));
  assign in_rdy = (state == S_RUN) &&
                  (!half_vld || !fifo_full);
  assign accept = in_vld && in_rdy;

  assign wr_busy     = (state == S_RUN) || (state == S_FLUSH);
  assign wr_done     = (state == S_DONE);
  assign wr_word_cnt = cnt;

  assign HSIZE  = 3'b010;
  assign HTRANS = (wstate == W_ADDR) ? 2'b10 : 2'b00;
  assign HWRITE = (wstate == W_ADDR);
  assign HADDR  = base + (32'(cnt) << 2);
  assign HWDATA = (wstate == W_DATA) ? mem[rd_ptr] : '0;

  always_comb begin
    state_nx  = state;
    push      = 1'b0;
    push_data = {in_data, half};
    unique case (state)
      S_IDLE, S_DONE: begin
        if (cfg_start) state_nx = S_RUN;
      end
      S_RUN: begin
        if (accept && half_vld) push = 1'b1;
        if (in_finish) state_nx = S_FLUSH;
      end
      S_FLUSH: begin
        // Odd tail goes out padded; completion waits for the writer to drain.
        if (half_vld && !fifo_full) begin
          push      = 1'b1;
          push_data = {PAD_VALUE, half};
        end else if (!half_vld && fifo_empty &&
                     (wstate == W_IDLE)) begin
          state_nx = S_DONE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    wstate_nx = wstate;
    pop       = 1'b0;
    unique case (wstate)
      W_IDLE: begin
        if (!fifo_empty) wstate_nx = W_ADDR;
      end
      W_ADDR: begin
        if (HREADY) wstate_nx = W_DATA;
      end
      W_DATA: begin
        if (HREADY) begin
          pop = 1'b1;
          if ((fcnt != (AW+1)'(1)) || push)
            wstate_nx = W_ADDR;
          else
            wstate_nx = W_IDLE;
        end
      end
      default: wstate_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      wstate <= W_IDLE;
      base   <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nx;
      wstate <= wstate_nx;
      if (start) begin
        base <= cfg_base_addr & ~32'h3;
        cnt  <= '0;
      end else if (pop) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half     <= '0;
      half_vld <= 1'b0;
    end else if (start) begin
      half_vld <= 1'b0;
    end else if (accept && !half_vld) begin
      half     <= in_data;
      half_vld <= 1'b1;
    end else if (push) begin
      half_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fcnt <= fcnt + (AW+1)'(1);
        2'b01:   fcnt <= fcnt - (AW+1)'(1);
        default: fcnt <= fcnt;
      endcase
    end
  end

`ifdef INFLATE_OUT_ADLER_EN
  logic [15:0] s1, s2;
  logic [15:0] s1a, s2a, s1b, s2b;

  function automatic logic [15:0] add_mod(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 17'd65521) s = s - 17'd65521;
    return s[15:0];
  endfunction

  // Low byte is the earlier one in the stream.
  always_comb begin
    s1a = add_mod(s1, {8'h0, in_data[7:0]});
    s2a = add_mod(s2, s1a);
    s1b = add_mod(s1a, {8'h0, in_data[15:8]});
    s2b = add_mod(s2a, s1b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 16'd1;
      s2 <= 16'd0;
    end else if (start) begin
      s1 <= 16'd1;
      s2 <= 16'd0;
    end else if (accept) begin
      s1 <= s1b;
      s2 <= s2b;
    end
  end

  assign adler_out = {s2, s1};
`endif

endmodule

// File: tb/tb_inflate_out_writer.sv
// Scoreboard bench for inflate_out_writer: expected AHB writes queued at
// stimulus time, checked by a bus monitor as data phases complete.
module tb_inflate_out_writer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_base_addr = '0;
  logic [15:0] in_data = '0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic        in_finish = 1'b0;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY = 1'b1;
  logic        wr_busy;
  logic        wr_done;
  logic [15:0] wr_word_cnt;
`ifdef INFLATE_OUT_ADLER_EN
  logic [31:0] adler_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_q[$];
  logic [31:0] m_base;
  int          m_cnt;
  logic [15:0] m_half;
  logic        m_hvld;

  always #5 clk = ~clk;

  inflate_out_writer #(
    .FIFO_DEPTH(DEPTH),
    .PAD_VALUE(16'h0),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_start(cfg_start),
    .cfg_base_addr(cfg_base_addr),
    .in_data(in_data),
    .in_vld(in_vld),
    .in_rdy(in_rdy),
    .in_finish(in_finish),
    .HADDR(HADDR),
    .HTRANS(HTRANS),
    .HWRITE(HWRITE),
    .HSIZE(HSIZE),
    .HWDATA(HWDATA),
    .HREADY(HREADY),
    .wr_busy(wr_busy),
    .wr_done(wr_done),
    .wr_word_cnt(wr_word_cnt)
`ifdef INFLATE_OUT_ADLER_EN
    ,
    .adler_out(adler_out)
`endif
  );

  // AHB monitor: address phase captured, compared when its data phase ends.
  logic        pend;
  logic [31:0] paddr;
  logic [63:0] e;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend && HREADY) begin
        pend = 1'b0;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL ahb_write unexpected got %h@%h want none",
                   HWDATA, paddr);
        end else begin
          e = exp_q.pop_front();
          if ({paddr, HWDATA} !== e) begin
            n_fail++;
            $display("FAIL ahb_write got %h@%h want %h@%h",
                     HWDATA, paddr, e[31:0], e[63:32]);
          end
        end
      end
      if (HTRANS == 2'b10 && HREADY) begin
        pend  = 1'b1;
        paddr = HADDR;
        n_tests++;
        if (HWRITE !== 1'b1) begin
          n_fail++;
          $display("FAIL hwrite got %b want 1", HWRITE);
        end
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back({m_base + 32'(m_cnt) * 32'd4, w});
    m_cnt++;
  endtask

  task automatic model_accept(input logic [15:0] d);
    if (!m_hvld) begin
      m_half = d;
      m_hvld = 1'b1;
    end else begin
      push_word({d, m_half});
      m_hvld = 1'b0;
    end
  endtask

  task automatic start_job(input logic [31:0] b);
    cfg_base_addr = b;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    m_base = b & ~32'h3;
    m_cnt  = 0;
    m_hvld = 1'b0;
  endtask

  task automatic send_half(input logic [15:0] d);
    int t = 0;
    in_data = d;
    in_vld  = 1'b1;
    @(negedge clk);
    while (in_rdy !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (in_rdy !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout got in_rdy=%b want 1", in_rdy);
    end else begin
      model_accept(d);
    end
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic finish_job();
    in_finish = 1'b1;
    @(posedge clk); #1;
    in_finish = 1'b0;
    if (m_hvld) begin
      push_word({16'h0, m_half});
      m_hvld = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (wr_done !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (wr_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done got %b want 1 (timeout)", tag, wr_done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({HTRANS, HADDR, HWDATA, HWRITE} !== '0) begin
      n_fail++;
      $display("FAIL reset_ahb got %b %h %h %b want 0",
               HTRANS, HADDR, HWDATA, HWRITE);
    end
    n_tests++;
    if (HSIZE !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_hsize got %b want 010", HSIZE);
    end
    n_tests++;
    if ({in_rdy, wr_busy, wr_done, wr_word_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl got rdy=%b busy=%b done=%b cnt=%0d want 0",
               in_rdy, wr_busy, wr_done, wr_word_cnt);
    end
`ifdef INFLATE_OUT_ADLER_EN
    n_tests++;
    if (adler_out !== 32'h1) begin
      n_fail++;
      $display("FAIL reset_adler got %h want 00000001", adler_out);
    end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    start_job(32'h100);
    n_tests++;
    if ({wr_busy, wr_done} !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_start got busy=%b done=%b want 1 0",
               wr_busy, wr_done);
    end
    send_half(16'h1111);
    send_half(16'h2222);
    // A start pulse while running must not disturb the job.
    cfg_base_addr = 32'h900;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    send_half(16'h3333);
    send_half(16'h4444);
    finish_job();
    wait_done("basic");
    n_tests++;
    if (wr_word_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL basic_cnt got %0d want 2", wr_word_cnt);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_drain got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_odd_tail();
    start_job(32'h2000);
    send_half(16'hAAAA);
    send_half(16'hBBBB);
    send_half(16'hCCCC);
    finish_job();
    wait_done("odd");
    n_tests++;
    if (wr_word_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL odd_cnt got %0d want 2", wr_word_cnt);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL odd_drain got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    start_job(32'h300);
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          send_half(16'h0100 + 16'(i));
          n_acc++;
        end
      end
      begin
        logic [31:0] a0, d0;
        logic        stable;
        int          t = 0;
        @(negedge clk);
        while (HTRANS !== 2'b10 && t < 100) begin
          @(negedge clk);
          t++;
        end
        @(posedge clk); #1;
        HREADY = 1'b0;
        @(negedge clk);
        a0 = HADDR;
        d0 = HWDATA;
        stable = 1'b1;
        repeat (20) begin
          @(negedge clk);
          if (HADDR !== a0 || HWDATA !== d0) stable = 1'b0;
        end
        n_tests++;
        if (!stable || a0 !== 32'h300 || d0 !== 32'h01010100) begin
          n_fail++;
          $display("FAIL bp_stall got %h@%h stable=%b want 01010100@300",
                   d0, a0, stable);
        end
        n_tests++;
        if (n_acc != 2 * DEPTH + 1 || in_rdy !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_fill got acc=%0d rdy=%b want %0d 0",
                   n_acc, in_rdy, 2 * DEPTH + 1);
        end
        @(posedge clk); #1;
        HREADY = 1'b1;
      end
    join
    finish_job();
    wait_done("bp");
    n_tests++;
    if (wr_word_cnt !== 16'd8 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_total got cnt=%0d left=%0d want 8 0",
               wr_word_cnt, exp_q.size());
    end
  endtask

  task automatic test_finish_coincide();
    logic ok;
    start_job(32'h400);
    send_half(16'h5555);
    in_data   = 16'h6666;
    in_vld    = 1'b1;
    in_finish = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL coin_rdy got %b want 1", in_rdy);
    end else begin
      model_accept(16'h6666);
    end
    @(posedge clk); #1;
    in_finish = 1'b0;
    in_data   = 16'h7777;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (in_rdy !== 1'b0) ok = 1'b0;
    end
    in_vld = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL coin_flush_rdy got 1 want 0");
    end
    wait_done("coin");
    n_tests++;
    if (wr_word_cnt !== 16'd1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL coin_cnt got cnt=%0d left=%0d want 1 0",
               wr_word_cnt, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    start_job(32'hFFFF_FFFE);
    send_half(16'h0A0B);
    send_half(16'h0C0D);
    send_half(16'h1A1B);
    send_half(16'h1C1D);
    finish_job();
    wait_done("wrap");
    n_tests++;
    if (wr_word_cnt !== 16'd2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_cnt got cnt=%0d left=%0d want 2 0",
               wr_word_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    start_job(32'h500);
    send_half(16'h1234);
    send_half(16'h5678);
    send_half(16'h9ABC);
    send_half(16'hDEF0);
    @(negedge clk);
    while (!(wr_word_cnt == 16'd1 && HTRANS == 2'b10) && t < 50) begin
      @(negedge clk);
      t++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({HTRANS, in_rdy, wr_done, wr_word_cnt} !== '0) begin
      n_fail++;
      $display("FAIL rstmid got htrans=%b rdy=%b done=%b cnt=%0d want 0",
               HTRANS, in_rdy, wr_done, wr_word_cnt);
    end
    exp_q.delete();
    m_hvld = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_job(32'h600);
    send_half(16'h1234);
    send_half(16'h5678);
    finish_job();
    wait_done("rstmid");
    n_tests++;
    if (wr_word_cnt !== 16'd1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rstmid_job got cnt=%0d left=%0d want 1 0",
               wr_word_cnt, exp_q.size());
    end
  endtask

  task automatic test_adler_empty();
    start_job(32'h700);
    send_half(16'h6261);
    send_half(16'h6463);
    finish_job();
    wait_done("abcd");
`ifdef INFLATE_OUT_ADLER_EN
    n_tests++;
    if (adler_out !== 32'h03D8018B) begin
      n_fail++;
      $display("FAIL adler_abcd got %h want 03d8018b", adler_out);
    end
`endif
    start_job(32'h800);
    finish_job();
    wait_done("empty");
    n_tests++;
    if (wr_word_cnt !== 16'd0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL empty_cnt got cnt=%0d left=%0d want 0 0",
               wr_word_cnt, exp_q.size());
    end
`ifdef INFLATE_OUT_ADLER_EN
    n_tests++;
    if (adler_out !== 32'h1) begin
      n_fail++;
      $display("FAIL adler_empty got %h want 00000001", adler_out);
    end
`endif
  endtask

  initial begin
    m_base = '0;
    m_cnt  = 0;
    m_half = '0;
    m_hvld = 1'b0;
    test_reset();
    test_basic();
    test_odd_tail();
    test_backpressure();
    test_finish_coincide();
    test_wrap();
    test_reset_mid();
    test_adler_empty();
    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
